// File: rtl/ternary_output_requant.sv
// Requantizing writeback stage: bias add, round/shift, saturate, optional ReLU, row FIFO to memory.
// Optional ReLU is built only when TERNARY_REQUANT_RELU_EN is defined.
module ternary_requant_lane #(
    parameter int ACC_BITS = 32,
    parameter int ACT_BITS = 16
) (
    input  logic                       clk,
    input  logic                       load,
    input  logic signed [ACC_BITS-1:0] acc,
    input  logic signed [ACC_BITS-1:0] bias,
    input  logic [4:0]                 shift,
    input  logic                       relu,
    output logic signed [ACT_BITS-1:0] act
);
    localparam int W = ACC_BITS + 2;
    localparam logic signed [W-1:0] SAT_MAX = (W'(1) <<< (ACT_BITS - 1)) - W'(1);
    localparam logic signed [W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [ACC_BITS:0] sum;
    logic signed [W-1:0]      wide, half, rnd;
    logic signed [ACT_BITS-1:0] sat;

    // S1: one extra bit so bias add never wraps; valid tracking lives in the top
    always_ff @(posedge clk)
        if (load) sum <= acc + bias;

    always_comb begin
        wide = {sum[ACC_BITS], sum};
        half = '0;
        if (shift != 5'd0) half = W'(1) << (shift - 5'd1);
        rnd  = (shift == 5'd0) ? wide : (wide + half) >>> shift;
        if (rnd > SAT_MAX)      sat = SAT_MAX[ACT_BITS-1:0];
        else if (rnd < SAT_MIN) sat = SAT_MIN[ACT_BITS-1:0];
        else                    sat = rnd[ACT_BITS-1:0];
    end

`ifdef TERNARY_REQUANT_RELU_EN
    assign act = (relu && sat[ACT_BITS-1]) ? '0 : sat;
`else
    logic unused_relu;
    assign unused_relu = relu;
    assign act = sat;
`endif
endmodule

module ternary_output_requant #(
    parameter int ARRAY_SIZE     = 8,
    parameter int ACC_BITS       = 32,
    parameter int ACT_BITS       = 16,
    parameter int OUT_ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [4:0]                              cfg_shift,
    input  logic                                    cfg_relu,
    input  logic [ARRAY_SIZE-1:0][ACC_BITS-1:0]     cfg_bias,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [OUT_ADDR_WIDTH-1:0]               in_addr,
    input  logic [ARRAY_SIZE-1:0][ACC_BITS-1:0]     in_data,
    output logic                                    mem_wr_valid,
    input  logic                                    mem_wr_ready,
    output logic [OUT_ADDR_WIDTH-1:0]               mem_wr_addr,
    output logic [ARRAY_SIZE-1:0][ACT_BITS-1:0]     mem_wr_data,
    output logic                                    busy,
    output logic                                    overflow,
    input  logic                                    clr_status,
    output logic [15:0]                             rows_written
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [OUT_ADDR_WIDTH-1:0]           addr;
        logic [ARRAY_SIZE-1:0][ACT_BITS-1:0] data;
    } row_t;

    logic                                push, pop, drop;
    logic                                s1_vld;
    logic [OUT_ADDR_WIDTH-1:0]           s1_addr;
    logic [ARRAY_SIZE-1:0][ACT_BITS-1:0] lane_act;
    row_t                                fifo_mem [FIFO_DEPTH];
    row_t                                head;
    logic [PTR_W-1:0]                    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]                    count;

    // Credit counts the S1 row too, so anything accepted always lands in the FIFO
    assign in_ready     = rst_n && ((count + CNT_W'(s1_vld)) < CNT_W'(FIFO_DEPTH));
    assign push         = in_valid & in_ready;
    assign drop         = in_valid & ~in_ready;
    assign mem_wr_valid = (count != '0);
    assign pop          = mem_wr_valid & mem_wr_ready;
    assign head         = fifo_mem[rd_ptr];
    assign mem_wr_addr  = mem_wr_valid ? head.addr : '0;
    assign mem_wr_data  = mem_wr_valid ? head.data : '0;
    assign busy         = s1_vld | mem_wr_valid;

    for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
        ternary_requant_lane #(.ACC_BITS(ACC_BITS), .ACT_BITS(ACT_BITS)) u_lane (
            .clk   (clk),
            .load  (push),
            .acc   (in_data[g]),
            .bias  (cfg_bias[g]),
            .shift (cfg_shift),
            .relu  (cfg_relu),
            .act   (lane_act[g])
        );
    end

    always_ff @(posedge clk) begin
        if (push) s1_addr <= in_addr;
        if (s1_vld) fifo_mem[wr_ptr] <= '{addr: s1_addr, data: lane_act};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld       <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            rows_written <= '0;
        end else begin
            s1_vld <= push;
            if (s1_vld) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
            case ({s1_vld, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // drop beats clear; clear beats an increment
            if (drop)            overflow <= 1'b1;
            else if (clr_status) overflow <= 1'b0;
            if (clr_status)      rows_written <= '0;
            else if (pop)        rows_written <= rows_written + 16'd1;
        end
    end
endmodule

// File: tb/tb_ternary_output_requant.sv
// Scoreboard bench for ternary_output_requant: model rows queued on accept, compared on memory write.
module tb_ternary_output_requant;
    localparam int N = 8;

    logic                clk, rst_n;
    logic [4:0]          cfg_shift;
    logic                cfg_relu;
    logic [N-1:0][31:0]  cfg_bias;
    logic                in_valid, in_ready;
    logic [11:0]         in_addr;
    logic [N-1:0][31:0]  in_data;
    logic                mem_wr_valid, mem_wr_ready;
    logic [11:0]         mem_wr_addr;
    logic [N-1:0][15:0]  mem_wr_data;
    logic                busy, overflow, clr_status;
    logic [15:0]         rows_written;

    ternary_output_requant dut (
        .clk(clk), .rst_n(rst_n), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .cfg_bias(cfg_bias), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .mem_wr_valid(mem_wr_valid),
        .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .busy(busy), .overflow(overflow),
        .clr_status(clr_status), .rows_written(rows_written)
    );

    typedef struct {
        logic [11:0] addr;
        logic [15:0] d [N];
    } exp_t;

    exp_t sb [$];
    int   checks = 0, failures = 0;
    int   pops = 0, pops_base = 0;
    int   lanes [N];
    int   bias  [N];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input longint acc, input longint b, input int sh, input bit relu);
        longint s, r;
        s = acc + b;
        if (sh == 0) r = s;
        else r = (s + (longint'(1) << (sh - 1))) >>> sh;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`ifdef TERNARY_REQUANT_RELU_EN
        if (relu && r < 0) r = 0;
`endif
        return r[15:0];
    endfunction

    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            exp_t e;
            e.addr = in_addr;
            for (int i = 0; i < N; i++)
                e.d[i] = model(longint'($signed(in_data[i])), longint'($signed(cfg_bias[i])),
                               int'(cfg_shift), cfg_relu);
            sb.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (rst_n && mem_wr_valid && mem_wr_ready) begin
            pops++;
            if (sb.size() == 0) chk("unexpected_pop", 64'd1, 64'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_addr", 64'(mem_wr_addr), 64'(e.addr));
                for (int i = 0; i < N; i++) chk("sb_lane", 64'(mem_wr_data[i]), 64'(e.d[i]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_inputs();
        for (int i = 0; i < N; i++) begin
            in_data[i]  = lanes[i];
            cfg_bias[i] = bias[i];
        end
    endtask

    task automatic drive_row(input logic [11:0] a);
        load_inputs();
        in_addr  = a;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        mem_wr_ready = 1'b1;
        while ((sb.size() != 0 || busy) && n < 200) begin
            step();
            n++;
        end
        chk("drain_timeout", 64'(n < 200), 64'd1);
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < N; i++) begin
            lanes[i] = 0;
            bias[i]  = 0;
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        cfg_shift = '0; cfg_relu = 1'b0; cfg_bias = '0;
        mem_wr_ready = 1'b0; clr_status = 1'b0;
        clear_lanes();
        step(); step();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_valid", 64'(mem_wr_valid), 64'd0);
        chk("rst_addr", 64'(mem_wr_addr), 64'd0);
        chk("rst_data", 64'(mem_wr_data != '0), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_rows", 64'(rows_written), 64'd0);
        rst_n = 1'b1;
        step();
        chk("rel_in_ready", 64'(in_ready), 64'd1);

        // passthrough with latency
        mem_wr_ready = 1'b1;
        lanes[0] = 100; lanes[1] = -5;
        drive_row(12'h010);
        chk("lat_t1", 64'(mem_wr_valid), 64'd0);
        step();
        chk("lat_t2", 64'(mem_wr_valid), 64'd1);
        chk("pt_addr", 64'(mem_wr_addr), 64'h010);
        chk("pt_l0", 64'(mem_wr_data[0]), 64'd100);
        chk("pt_l1", 64'(mem_wr_data[1]), 64'hFFFB);
        drain();
        chk("pt_rows", 64'(rows_written), 64'd1);

        // rounding
        cfg_shift = 5'd2;
        lanes[0] = 7; lanes[1] = -7; lanes[2] = 6; lanes[3] = -6;
        drive_row(12'h020);
        step();
        chk("rnd_l0", 64'(mem_wr_data[0]), 64'd2);
        chk("rnd_l1", 64'(mem_wr_data[1]), 64'hFFFE);
        chk("rnd_l2", 64'(mem_wr_data[2]), 64'd2);
        chk("rnd_l3", 64'(mem_wr_data[3]), 64'hFFFF);
        drain();
        bias[0] = 1;
        drive_row(12'h021);
        step();
        chk("rnd_bias", 64'(mem_wr_data[0]), 64'd2);
        drain();

        // saturation
        cfg_shift = 5'd0;
        clear_lanes();
        lanes[0] = 40000; lanes[1] = -40000; lanes[2] = 32'h7FFF_FFFF; bias[2] = 1;
        drive_row(12'h030);
        step();
        chk("sat_hi", 64'(mem_wr_data[0]), 64'h7FFF);
        chk("sat_lo", 64'(mem_wr_data[1]), 64'h8000);
        chk("sat_nowrap", 64'(mem_wr_data[2]), 64'h7FFF);
        drain();

        // backpressure / overflow
        clear_lanes();
        mem_wr_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            lanes[0] = 1000 + i;
            load_inputs();
            in_addr  = 12'h100 + 12'(i);
            in_valid = 1'b1;
            chk("bp_in_ready", 64'(in_ready), 64'(i < 4));
            step();
        end
        in_valid = 1'b0;
        step();
        chk("bp_ovf", 64'(overflow), 64'd1);
        chk("bp_busy", 64'(busy), 64'd1);
        mem_wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_burst_valid", 64'(mem_wr_valid), 64'd1);
            chk("bp_burst_addr", 64'(mem_wr_addr), 64'(12'h100 + 12'(i)));
            step();
        end
        chk("bp_empty", 64'(mem_wr_valid), 64'd0);
        chk("bp_rows", 64'(rows_written), 64'(16'(pops - pops_base)));
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        pops_base = pops;
        chk("clr_ovf", 64'(overflow), 64'd0);
        chk("clr_rows", 64'(rows_written), 64'd0);

        // ReLU
        cfg_relu = 1'b1;
        lanes[0] = -5; lanes[1] = 9;
        drive_row(12'h040);
        step();
`ifdef TERNARY_REQUANT_RELU_EN
        chk("relu_neg", 64'(mem_wr_data[0]), 64'd0);
`else
        chk("relu_neg", 64'(mem_wr_data[0]), 64'hFFFB);
`endif
        chk("relu_pos", 64'(mem_wr_data[1]), 64'd9);
        drain();
        cfg_relu = 1'b0;

        // random traffic with random backpressure
        cfg_shift = 5'd7;
        for (int i = 0; i < N; i++) bias[i] = int'($urandom_range(0, 4000)) - 2000;
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < N; i++) lanes[i] = int'($urandom);
            load_inputs();
            in_addr      = 12'($urandom);
            in_valid     = 1'($urandom);
            mem_wr_ready = 1'($urandom);
            step();
        end
        in_valid = 1'b0;
        drain();
        chk("rand_rows", 64'(rows_written), 64'(16'(pops - pops_base)));

        // reset mid-stream
        cfg_shift = 5'd0;
        clear_lanes();
        mem_wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lanes[0] = i;
            drive_row(12'h200 + 12'(i));
        end
        step();
        chk("mid_busy_pre", 64'(busy), 64'd1);
        rst_n = 1'b0;
        sb.delete();
        step();
        rst_n = 1'b1;
        pops_base = pops;
        chk("mid_valid", 64'(mem_wr_valid), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_rows", 64'(rows_written), 64'd0);
        mem_wr_ready = 1'b1;
        repeat (5) step();
        chk("mid_no_emit", 64'(pops), 64'(pops_base));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ternary_output_requant.md
# ternary_output_requant

Writeback stage directly downstream of the ternary systolic controller. It consumes the controller's result rows: one row per cycle of ARRAY_SIZE signed accumulator lanes plus an output address. Each lane gets a per-lane bias added, is rounded, shifted and saturated to activation width, and the row is buffered in a small FIFO. Rows are then written to the output/activation buffer over a valid/ready handshake, so the next layer can consume them as activations.

## Interface
- ARRAY_SIZE, 8, lanes per row
- ACC_BITS, 32, signed accumulator width of incoming lanes and bias
- ACT_BITS, 16, signed output activation width
- OUT_ADDR_WIDTH, 12, row address width
- FIFO_DEPTH, 4, output row FIFO entries (power of two, ≥4)

Ports:
- clk  in  1  clock. One clock domain.
- rst_n  in  1  synchronous, active-low reset.
- cfg_shift  in  5  right-shift amount 0..31; must be static while busy=1
- cfg_relu  in  1  ReLU enable (see Configuration); static while busy=1
- cfg_bias  in  ARRAY_SIZE×ACC_BITS signed  per-lane bias; static while busy=1
- in_valid  in  1  result row present (driven by controller out_wr_en)
- in_ready  out  1  row accepted this cycle if in_valid is also high
- in_addr  in  OUT_ADDR_WIDTH  row address
- in_data  in  ARRAY_SIZE×ACC_BITS signed  accumulator row
- mem_wr_valid  out  1  FIFO head valid
- mem_wr_ready  in  1  memory accepts the head
- mem_wr_addr  out  OUT_ADDR_WIDTH  head address
- mem_wr_data  out  ARRAY_SIZE×ACT_BITS signed  head data
- busy  out  1  pipeline or FIFO non-empty
- overflow  out  1  sticky: a row was dropped
- clr_status  in  1  clears overflow and rows_written
- rows_written  out  16  rows transferred to memory, wraps at 2^16

## Operation
- Accept: push = in_valid & in_ready. A row presented with in_ready=0 is dropped and overflow is set. The upstream controller cannot stall, so overflow is the only indication of a lost row.
- Credit rule: in_ready = (fifo_count + rows in stages S1/S2) < FIFO_DEPTH. A row already in the pipeline therefore always finds a FIFO slot.
- Stage S1 (register): sum[i] = sext(in_data[i]) + sext(cfg_bias[i]), computed at ACC_BITS+1 bits, so it never wraps. The address travels alongside.
- Stage S2 (register):
  - If cfg_shift = 0: r = sum.
  - Otherwise: r = (sum + 2^(cfg_shift−1)) >>> cfg_shift, computed at ACC_BITS+2 bits (round half toward +∞).
  - Saturate r to [−2^(ACT_BITS−1), 2^(ACT_BITS−1)−1].
  - Apply ReLU if enabled.
  - Write the row into the FIFO.
- FIFO: first-word fall-through. The head drives mem_wr_* whenever it is non-empty. A pop occurs on mem_wr_valid & mem_wr_ready. A push and a pop in the same cycle leave the count unchanged, including when the FIFO is full.
- Order is strictly preserved from in_* to mem_wr_*.
- rows_written increments on every pop.
- clr_status in the same cycle as a pop: the counter ends at 0.
- clr_status in the same cycle as a drop: overflow ends at 1 (set wins).

## Timing
- Latency: a row pushed at cycle t appears on mem_wr_valid at t+2 when the FIFO is empty and mem_wr_ready is held.
- Throughput: 1 row/cycle sustained when mem_wr_ready stays high.
- mem_wr_valid must never drop before its handshake completes. mem_wr_addr/data stay stable while valid=1 and ready=0.
- Reset (rst_n low at a clock edge):
  - Pipeline and FIFO empty.
  - mem_wr_valid=0, mem_wr_addr=0, mem_wr_data=0.
  - busy=0, overflow=0, rows_written=0.
  - in_ready=0 while rst_n=0, and 1 on the first cycle after release.
- Reset mid-operation discards all in-flight and buffered rows, with no partial write.
- busy falls the cycle after the last pop, once S1/S2 are empty.

## Configuration
- TERNARY_REQUANT_RELU_EN
  - Defined: when cfg_relu=1, negative saturated results become 0. When cfg_relu=0, results pass through unchanged.
  - Undefined: the ReLU logic is not built and cfg_relu is ignored; results are always signed saturated values.
- The port list is identical in both builds.

## Test plan
- Passthrough: bias=0, shift=0, row {100, −5, 0, …} at addr 0x010 with ready held → mem_wr row {100, −5, 0, …}, addr 0x010, valid at t+2, rows_written=1.
- Rounding: shift=2, bias=0, lanes {7, −7, 6, −6} → {2, −2, 2, −1}. With bias lane0=1 and input 7 → 2.
- Saturation: shift=0, lanes {40000, −40000} → {32767, −32768}. Lane 0x7FFFFFFF with bias 1 → 32767 (no wrap).
- Backpressure/overflow: mem_wr_ready=0, stream 6 consecutive rows → first 4 accepted; in_ready low from the cycle credit hits 4; rows 5–6 dropped; overflow=1. Raise ready → 4 rows out in order on consecutive cycles. clr_status → overflow=0, rows_written=0.
- ReLU: cfg_relu=1, lane −5 → 0 with TERNARY_REQUANT_RELU_EN defined, −5 without it. Lane 9 → 9 in both builds.
- Reset mid-stream: 3 rows buffered with ready=0, pulse rst_n low for 1 cycle → mem_wr_valid=0, busy=0, no rows emitted after ready rises.
